// File: rtl/wb_stage_pipe_if.sv
// Bundle of MEM-stage, data-cache and register-file signals around the
// writeback stage.
//
// Handshake: an instruction transfers on a rising clk edge where
// in_valid && in_ready are both 1. in_ready is combinational from stage state
// and does not depend on in_valid. While in_ready is 0, every instruction
// input is ignored. cache_data_out is only looked at when cache_ready is 1.
//
// Modports:
//   slave  - the writeback stage (takes instruction/cache inputs, drives the
//            register-file write port, the forwarding copy, the counter and
//            state_dbg)
//   master - the surrounding pipeline / testbench
interface wb_stage_pipe_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);

  logic                                in_valid;
  logic                                in_ready;
  logic                                reg_write;
  logic [REG_ADDR_WIDTH-1:0]           dest_reg;
  logic                                mem_to_reg;
  logic [1:0]                          load_size;
  logic                                load_unsigned;
  logic [OFF_W-1:0]                    mem_block;
  logic [1:0]                          jump;
  logic [DATA_WIDTH-1:0]               pc;
  logic [DATA_WIDTH-1:0]               alu_result;
  // Lane 0 is the most significant byte (big-endian line word).
  logic [0:BYTES-1][7:0]               cache_data_out;
  logic                                cache_ready;
  logic                                stall;
  logic                                rf_write_en;
  logic [REG_ADDR_WIDTH-1:0]           rf_write_addr;
  logic [DATA_WIDTH-1:0]               rf_write_data;
  logic                                misalign_err;
  logic                                fwd_valid;
  logic [REG_ADDR_WIDTH-1:0]           fwd_reg;
  logic [DATA_WIDTH-1:0]               fwd_data;
  logic [31:0]                         retired_count;
  // Current FSM state: 0 = IDLE, 1 = WAIT_CACHE.
  logic                                state_dbg;

  modport slave (
    input  in_valid, reg_write, dest_reg, mem_to_reg, load_size, load_unsigned,
           mem_block, jump, pc, alu_result, cache_data_out, cache_ready,
    output in_ready, stall, rf_write_en, rf_write_addr, rf_write_data,
           misalign_err, fwd_valid, fwd_reg, fwd_data, retired_count, state_dbg
  );

  modport master (
    output in_valid, reg_write, dest_reg, mem_to_reg, load_size, load_unsigned,
           mem_block, jump, pc, alu_result, cache_data_out, cache_ready,
    input  in_ready, stall, rf_write_en, rf_write_addr, rf_write_data,
           misalign_err, fwd_valid, fwd_reg, fwd_data, retired_count, state_dbg
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage of the MIPS pipeline.
//
// Picks the writeback value (aligned/extended load data, pc + LINK_OFFSET for
// link writes, or the ALU result) and drives a registered register-file write
// port, a forwarding copy of the last write and a retire counter. A load
// whose cache data is not ready parks in WAIT_CACHE with stall=1 until
// cache_ready arrives.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_b - synchronous active-low reset
//   bus   - wb_stage_pipe_if.slave (instruction inputs, cache data,
//           register-file write port, forwarding, retire counter, state_dbg)
module wb_stage_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_OFFSET    = 8
) (
  input  logic           clk,
  input  logic           rst_b,
  wb_stage_pipe_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]                state_q, state_d;
  logic                      lat_rw_q, lat_rw_d;
  logic [REG_ADDR_WIDTH-1:0] lat_dest_q, lat_dest_d;
  logic [1:0]                lat_size_q, lat_size_d;
  logic                      lat_uns_q, lat_uns_d;
  logic [OFF_W-1:0]          lat_blk_q, lat_blk_d;

  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      mis_q, mis_d;
  logic                      fv_q, fv_d;
  logic [REG_ADDR_WIDTH-1:0] freg_q, freg_d;
  logic [DATA_WIDTH-1:0]     fdata_q, fdata_d;
  logic [31:0]               cnt_q, cnt_d;

  logic                      is_idle;
  logic                      accept;
  logic                      retire;
  logic                      sel_load;
  logic                      sel_rw;
  logic [REG_ADDR_WIDTH-1:0] sel_dest;
  logic [1:0]                sel_size;
  logic                      sel_uns;
  logic [OFF_W-1:0]          sel_blk;
  logic [OFF_W-1:0]          h_idx;
  logic [OFF_W-1:0]          h_idx1;
  logic [7:0]                byte_v;
  logic [15:0]               half_v;
  logic [DATA_WIDTH-1:0]     load_val;
  logic [DATA_WIDTH-1:0]     wb_val;
  logic                      misaligned;

  assign is_idle       = (state_q == S_IDLE);
  assign bus.in_ready  = rst_b && is_idle;
  assign bus.stall     = rst_b && (state_q == S_WAIT);
  assign bus.state_dbg = state_q[0];
  assign accept        = bus.in_valid && bus.in_ready;

  // In IDLE the live inputs describe the instruction; in WAIT_CACHE it is
  // always the parked load, described by the latched fields.
  always_comb begin
    sel_load = is_idle ? bus.mem_to_reg    : 1'b1;
    sel_rw   = is_idle ? bus.reg_write     : lat_rw_q;
    sel_dest = is_idle ? bus.dest_reg      : lat_dest_q;
    sel_size = is_idle ? bus.load_size     : lat_size_q;
    sel_uns  = is_idle ? bus.load_unsigned : lat_uns_q;
    sel_blk  = is_idle ? bus.mem_block     : lat_blk_q;
  end

  // Load extraction. A misaligned half uses the pair containing the offset
  // (bit 0 cleared); a misaligned word still returns the whole line word.
  always_comb begin
    h_idx  = sel_blk & ~OFF_W'(1);
    h_idx1 = h_idx | OFF_W'(1);
    byte_v = bus.cache_data_out[sel_blk];
    half_v = {bus.cache_data_out[h_idx], bus.cache_data_out[h_idx1]};
    case (sel_size)
      2'b00:   load_val = sel_uns ? DATA_WIDTH'(byte_v)
                                  : {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      2'b01:   load_val = sel_uns ? DATA_WIDTH'(half_v)
                                  : {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      default: load_val = bus.cache_data_out;
    endcase
    case (sel_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = sel_blk[0];
      default: misaligned = (sel_blk != '0);
    endcase
    if (sel_load)
      wb_val = load_val;
    else if (bus.jump == 2'b10)
      wb_val = bus.pc + DATA_WIDTH'(LINK_OFFSET);
    else
      wb_val = bus.alu_result;
  end

  assign retire = (accept && (!bus.mem_to_reg || bus.cache_ready)) ||
                  (!is_idle && bus.cache_ready);

  always_comb begin
    state_d    = state_q;
    lat_rw_d   = lat_rw_q;
    lat_dest_d = lat_dest_q;
    lat_size_d = lat_size_q;
    lat_uns_d  = lat_uns_q;
    lat_blk_d  = lat_blk_q;
    we_d       = 1'b0;
    mis_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    fv_d       = fv_q;
    freg_d     = freg_q;
    fdata_d    = fdata_q;
    cnt_d      = cnt_q;

    if (accept && bus.mem_to_reg && !bus.cache_ready) begin
      state_d    = S_WAIT;
      lat_rw_d   = bus.reg_write;
      lat_dest_d = bus.dest_reg;
      lat_size_d = bus.load_size;
      lat_uns_d  = bus.load_unsigned;
      lat_blk_d  = bus.mem_block;
    end else if (!is_idle && bus.cache_ready) begin
      state_d = S_IDLE;
    end

    if (retire) begin
      cnt_d = cnt_q + 32'd1;
      mis_d = sel_load && misaligned;
      if (sel_rw && (sel_dest != '0)) begin
        we_d    = 1'b1;
        waddr_d = sel_dest;
        wdata_d = wb_val;
        fv_d    = 1'b1;
        freg_d  = sel_dest;
        fdata_d = wb_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      lat_rw_q   <= 1'b0;
      lat_dest_q <= '0;
      lat_size_q <= '0;
      lat_uns_q  <= 1'b0;
      lat_blk_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      fv_q       <= 1'b0;
      freg_q     <= '0;
      fdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lat_rw_q   <= lat_rw_d;
      lat_dest_q <= lat_dest_d;
      lat_size_q <= lat_size_d;
      lat_uns_q  <= lat_uns_d;
      lat_blk_q  <= lat_blk_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      mis_q      <= mis_d;
      fv_q       <= fv_d;
      freg_q     <= freg_d;
      fdata_q    <= fdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.rf_write_en   = we_q;
  assign bus.rf_write_addr = waddr_q;
  assign bus.rf_write_data = wdata_q;
  assign bus.misalign_err  = mis_q;
  assign bus.fwd_valid     = fv_q;
  assign bus.fwd_reg       = freg_q;
  assign bus.fwd_data      = fdata_q;
  assign bus.retired_count = cnt_q;
endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  wb_stage_pipe_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  wb_stage_pipe #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .LINK_OFFSET(LO)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  // ---------------- checking ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  bit          m_pend;
  bit          m_rw;
  int          m_dest, m_size, m_blk;
  bit          m_uns;
  bit          m_we, m_mis, m_fv;
  logic [31:0] m_addr, m_data, m_freg, m_fdata, m_cnt;

  // Big-endian line word: lane i occupies bits [31-8i -: 8].
  function automatic logic [31:0] ref_load(input logic [31:0] line, input int size,
                                           input bit uns, input int blk);
    int     lanes[4];
    int     h;
    longint v;
    for (int i = 0; i < 4; i++) lanes[i] = int'((line >> (8 * (3 - i))) & 32'hFF);
    if (size == 0) begin
      v = lanes[blk];
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 1) begin
      h = blk - (blk % 2);
      v = lanes[h] * 256 + lanes[h + 1];
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(line);
    end
    return v[31:0];
  endfunction

  task automatic model_edge();
    bit          ret;
    bit          r_rw, r_mem;
    int          r_dest, r_size, r_blk;
    logic [31:0] val;
    ret = 0; r_rw = 0; r_mem = 0; r_dest = 0; r_size = 0; r_blk = 0; val = 0;
    m_we = 0; m_mis = 0;
    if (rst_b !== 1'b1) begin
      m_pend = 0; m_fv = 0; m_addr = 0; m_data = 0;
      m_freg = 0; m_fdata = 0; m_cnt = 0;
    end else if (m_pend) begin
      if (bus.cache_ready) begin
        ret = 1; r_mem = 1; r_rw = m_rw; r_dest = m_dest; r_size = m_size; r_blk = m_blk;
        val = ref_load(bus.cache_data_out, m_size, m_uns, m_blk);
        m_pend = 0;
      end
    end else if (bus.in_valid) begin
      if (bus.mem_to_reg && !bus.cache_ready) begin
        m_pend = 1; m_rw = bus.reg_write; m_dest = int'(bus.dest_reg);
        m_size = int'(bus.load_size); m_uns = bus.load_unsigned; m_blk = int'(bus.mem_block);
      end else begin
        ret = 1; r_mem = bus.mem_to_reg; r_rw = bus.reg_write; r_dest = int'(bus.dest_reg);
        r_size = int'(bus.load_size); r_blk = int'(bus.mem_block);
        if (bus.mem_to_reg)
          val = ref_load(bus.cache_data_out, r_size, bus.load_unsigned, r_blk);
        else if (bus.jump == 2'b10)
          val = bus.pc + LO;
        else
          val = bus.alu_result;
      end
    end
    if (ret) begin
      m_cnt = m_cnt + 1;
      m_mis = r_mem && ((r_size == 1) ? (r_blk % 2 == 1) : (r_size >= 2) ? (r_blk != 0) : 1'b0);
      if (r_rw && r_dest != 0) begin
        m_we = 1; m_addr = r_dest; m_data = val;
        m_fv = 1; m_freg = r_dest; m_fdata = val;
        exp_q.push_back(val);
      end
    end
  endtask

  task automatic check_outputs();
    check("in_ready", bus.in_ready, rst_b && !m_pend);
    check("stall", bus.stall, rst_b && m_pend);
    check("rf_write_en", bus.rf_write_en, m_we);
    check("rf_write_addr", bus.rf_write_addr, m_addr);
    check("rf_write_data", bus.rf_write_data, m_data);
    check("misalign_err", bus.misalign_err, m_mis);
    check("fwd_valid", bus.fwd_valid, m_fv);
    check("fwd_reg", bus.fwd_reg, m_freg);
    check("fwd_data", bus.fwd_data, m_fdata);
    check("retired_count", bus.retired_count, m_cnt);
    if (bus.rf_write_en === 1'b1) begin
      if (exp_q.size() > 0) check("sb_data", bus.rf_write_data, exp_q.pop_front());
      else check("sb_unexpected_write", bus.rf_write_en, 1'b0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input bit rw, input int dest, input bit mem,
                       input int size, input bit uns, input int blk, input int jmp,
                       input logic [31:0] pcv, input logic [31:0] alu,
                       input logic [31:0] line, input bit crdy);
    bus.in_valid       = v;
    bus.reg_write      = rw;
    bus.dest_reg       = AW'(dest);
    bus.mem_to_reg     = mem;
    bus.load_size      = 2'(size);
    bus.load_unsigned  = uns;
    bus.mem_block      = 2'(blk);
    bus.jump           = 2'(jmp);
    bus.pc             = pcv;
    bus.alu_result     = alu;
    bus.cache_data_out = line;
    bus.cache_ready    = crdy;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_pend = 0; m_rw = 0; m_dest = 0; m_size = 0; m_blk = 0; m_uns = 0;
    m_we = 0; m_mis = 0; m_fv = 0; m_addr = 0; m_data = 0; m_freg = 0; m_fdata = 0; m_cnt = 0;
    rst_b = 1'b0;
    idle_in();
    #1;
    tick();
    tick();
    check("rst_in_ready_low", bus.in_ready, 1'b0);
    check("rst_count_zero", bus.retired_count, 32'd0);
    rst_b = 1'b1;
    tick();

    // ALU op
    drive(1, 1, 5, 0, 0, 0, 0, 0, 32'h0, 32'h1234, 32'h0, 0);
    tick();
    check("alu_we", bus.rf_write_en, 1'b1);
    check("alu_addr", bus.rf_write_addr, 5);
    check("alu_data", bus.rf_write_data, 32'h00001234);
    check("alu_count", bus.retired_count, 1);
    idle_in();
    tick();

    // link write
    drive(1, 1, 31, 0, 0, 0, 0, 2, 32'h00400010, 32'hDEAD, 32'h0, 0);
    tick();
    check("link_data", bus.rf_write_data, 32'h00400018);

    // signed byte, lane 2 = 0x80
    drive(1, 1, 3, 1, 0, 0, 2, 0, 32'h0, 32'h0, 32'h00008000, 1);
    tick();
    check("sbyte_data", bus.rf_write_data, 32'hFFFFFF80);

    // unsigned half, lanes 2,3 = 0x8001
    drive(1, 1, 4, 1, 1, 1, 2, 0, 32'h0, 32'h0, 32'hAAAA8001, 1);
    tick();
    check("uhalf_data", bus.rf_write_data, 32'h00008001);

    // word load stalled three cycles; inputs during the stall are ignored
    drive(1, 1, 9, 1, 2, 0, 0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 0);
    tick();
    check("stall_c1", bus.stall, 1'b1);
    drive(1, 1, 10, 0, 0, 0, 0, 0, 32'h0, 32'h5555, 32'h0, 0);
    tick();
    check("stall_c2", bus.stall, 1'b1);
    tick();
    check("stall_c3", bus.stall, 1'b1);
    check("stall_in_ready", bus.in_ready, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h11223344, 1);
    tick();
    check("word_we", bus.rf_write_en, 1'b1);
    check("word_data", bus.rf_write_data, 32'h11223344);
    check("word_stall_gone", bus.stall, 1'b0);
    idle_in();
    tick();
    check("word_once", bus.rf_write_en, 1'b0);

    // misaligned half
    drive(1, 1, 7, 1, 1, 0, 1, 0, 32'h0, 32'h0, 32'h12345678, 1);
    tick();
    check("mis_err", bus.misalign_err, 1'b1);
    check("mis_we", bus.rf_write_en, 1'b1);
    check("mis_data", bus.rf_write_data, 32'h00001234);

    // dest 0: retire without write
    drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h77, 32'h0, 0);
    tick();
    check("r0_no_we", bus.rf_write_en, 1'b0);
    check("r0_count", bus.retired_count, 7);

    // reset during WAIT_CACHE
    drive(1, 1, 12, 1, 2, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    tick();
    idle_in();
    rst_b = 1'b0;
    tick();
    check("rstw_stall", bus.stall, 1'b0);
    check("rstw_fwd_valid", bus.fwd_valid, 1'b0);
    check("rstw_data", bus.rf_write_data, 32'h0);
    check("rstw_state", bus.state_dbg, 1'b0);
    rst_b = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hCAFEF00D, 1);
    tick();
    check("rstw_no_write", bus.rf_write_en, 1'b0);
    drive(1, 1, 6, 0, 0, 0, 0, 0, 32'h0, 32'h0BEEF, 32'h0, 0);
    tick();
    check("post_rst_data", bus.rf_write_data, 32'h0000BEEF);
    check("post_rst_count", bus.retired_count, 1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_b = ($urandom_range(0, 79) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31)),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) != 0);
      tick();
    end
    rst_b = 1'b1;
    idle_in();
    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised, registered writeback stage for the MIPS pipeline. It sits between the MEM stage / data cache and the register file. It selects the writeback value: aligned and extended load data, link address (pc + LINK_OFFSET) or ALU result. It supports byte, halfword and word loads, signed or unsigned. When a load's cache data is not yet available it stalls the pipeline with a two-state handshake, then drives a registered register-file write port, a forwarding copy and a retire counter.

## Interface
Parameters:
- DATA_WIDTH, 32: datapath width; multiple of 16. BYTES = DATA_WIDTH/8 lanes.
- REG_ADDR_WIDTH, 5: register-file address width.
- LINK_OFFSET, 8: added to pc for link writes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_b  in  1  reset; synchronous, active-low.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage accepts this cycle. Equals 1 only in IDLE with rst_b high.
- reg_write  in  1  instruction writes a register.
- dest_reg  in  REG_ADDR_WIDTH  destination register.
- mem_to_reg  in  1  instruction is a load.
- load_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned  in  1  1 zero-extend, 0 sign-extend.
- mem_block  in  $clog2(BYTES)  byte-lane offset of the access.
- jump  in  2  10 selects link write.
- pc  in  DATA_WIDTH  instruction pc.
- alu_result  in  DATA_WIDTH  ALU result.
- cache_data_out  in  [7:0] x [0:BYTES-1]  cache line word; lane 0 is the most significant (big-endian).
- cache_ready  in  1  cache_data_out valid this cycle.
- stall  out  1  1 while waiting for cache data.
- rf_write_en  out  1  register-file write strobe, one cycle per retire.
- rf_write_addr  out  REG_ADDR_WIDTH  write address.
- rf_write_data  out  DATA_WIDTH  write data.
- misalign_err  out  1  one-cycle pulse with the retire of a misaligned load.
- fwd_valid  out  1  fwd_reg/fwd_data hold the last committed write.
- fwd_reg  out  REG_ADDR_WIDTH  last written register.
- fwd_data  out  DATA_WIDTH  last written data.
- retired_count  out  32  number of retired instructions, wraps.

## Operation
- States: IDLE, WAIT_CACHE.
- IDLE, accept when in_valid && in_ready. Then:
  - Not a load, or load with cache_ready=1: the result is computed this cycle and registered. Stay in IDLE.
  - Load with cache_ready=0: latch dest_reg, reg_write, load_size, load_unsigned and mem_block. Go to WAIT_CACHE.
- WAIT_CACHE:
  - stall=1, in_ready=0; new inputs are ignored.
  - On cache_ready=1: compute from cache_data_out and the latched fields, register the result, return to IDLE.
- Value select priority: mem_to_reg, then jump==10 (pc + LINK_OFFSET, truncated to DATA_WIDTH), then alu_result.
- Load extraction:
  - Word: concatenate lane 0..BYTES-1, most significant first.
  - Half: lanes {h, h+1} with h = mem_block with bit 0 cleared.
  - Byte: lane mem_block.
  - Extension: sign-extend from bit 7 (byte) or bit 15 (half) when load_unsigned=0; zero-extend otherwise.
- Misaligned access: half with mem_block[0]=1, or word with mem_block!=0. Data uses the rule above, and misalign_err pulses with rf_write_en.
- Retire:
  - rf_write_en=1 only if reg_write=1 and dest_reg!=0.
  - retired_count increments on every retire, including non-writing ones.
- Forwarding: on every rf_write_en, load fwd_reg and fwd_data and set fwd_valid=1. They hold until the next write.
- Reset (rst_b low at an edge):
  - state goes to IDLE; latched fields are discarded.
  - rf_write_en, misalign_err, fwd_valid, rf_write_addr, rf_write_data, fwd_reg, fwd_data and retired_count go to 0.
  - stall=0 and in_ready=0 while rst_b is low.
  - A reset during WAIT_CACHE abandons the pending load with no write.

## Timing
- Latency:
  - 1 cycle from acceptance to rf_write_en for a non-stalled instruction.
  - 1 cycle from the cache_ready edge to rf_write_en for a stalled load.
- Throughput: one instruction per cycle when no stall occurs.
- stall rises combinationally once in WAIT_CACHE, i.e. in the cycle after the accepting edge, and falls in the cycle after cache_ready is sampled.
- rf_write_en and misalign_err are single-cycle pulses. All outputs except in_ready and stall are registered.
- fwd_* update on the same edge as rf_write_en.
- retired_count wraps from 0xFFFFFFFF to 0.

## Test plan
- ALU op, dest_reg=5, alu_result=0x1234 -> next cycle rf_write_en=1, addr 5, data 0x00001234; retired_count=1.
- Link, jump=10, pc=0x00400010, dest 31 -> rf_write_data=0x00400018.
- Signed byte load, lane 2=0x80, cache_ready=1 -> 0xFFFFFF80. Unsigned half, mem_block=2, lanes 2,3=0x8001 -> 0x00008001.
- Word load, cache_ready low for 3 cycles then high with lanes 0x11,0x22,0x33,0x44 -> stall=1 for 3 cycles, in_ready=0; the cycle after cache_ready, 0x11223344 is written once.
- Half load with mem_block=1 -> misalign_err pulse together with rf_write_en. dest_reg=0 -> no write, retired_count still increments.
- rst_b low during WAIT_CACHE -> no write; state IDLE; all outputs 0. After release, an immediate ALU op retires normally.
